// File: rtl/cpu_pkg.sv
// Shared CPU constants: address/instruction widths, reset vector and the
// bubble instruction used by the front end.
package cpu_pkg;

   localparam int ADDR_W  = 14;
   localparam int INSTR_W = 32;

   localparam logic [ADDR_W-1:0]  RESET_PC  = 14'h0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [ADDR_W-1:0]  PC_STEP   = 14'd4;

   // Word-align a byte address by clearing the two low bits.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that catches an imem response
// arriving while the decode stage is stalled.
module fetch_skid_buf
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_drain,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [ADDR_W-1:0]  i_pc,
   output logic               o_vld,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_pc
);

   logic               r_vld;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc;

   // Clear (reset or redirect) dominates so a flushed response never drains.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_vld <= 1'b0;
      end else if (i_load) begin
         r_vld <= 1'b1;
      end else if (i_drain) begin
         r_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end

   assign o_vld   = r_vld;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches to a 1-cycle
// synchronous imem and registers {instr, pc, valid} toward IF/ID.
module instr_fetch
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               flush_o,
   output logic               imem_en_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               valid_o
);

   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [ADDR_W-1:0]  r_req_pc;
   logic               r_req_vld;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_valid;

   logic               w_issue;
   logic               w_skid_load;
   logic               w_skid_drain;
   logic               w_skid_vld;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [ADDR_W-1:0]  w_skid_pc;

   assign w_issue      = rst_n & ~redirect_i & ~stall_i;
   assign w_skid_load  = rst_n & ~redirect_i & stall_i & r_req_vld;
   assign w_skid_drain = ~stall_i;

   assign flush_o     = redirect_i & rst_n;
   assign imem_en_o   = w_issue;
   assign imem_addr_o = r_fetch_pc;

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_skid_load),
      .i_drain (w_skid_drain),
      .i_clear (redirect_i),
      .i_instr (imem_rdata_i),
      .i_pc    (r_req_pc),
      .o_vld   (w_skid_vld),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_req_vld  <= 1'b0;
         r_valid    <= 1'b0;
         r_instr    <= NOP_INSTR;
         r_pc       <= '0;
      end else if (redirect_i) begin
         // In-flight response is dropped; pc_o keeps its last value.
         r_fetch_pc <= word_align(redirect_pc_i);
         r_req_vld  <= 1'b0;
         r_valid    <= 1'b0;
         r_instr    <= NOP_INSTR;
      end else begin
         r_req_vld <= w_issue;
         if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
         if (!stall_i) begin
            if (w_skid_vld) begin
               r_valid <= 1'b1;
               r_instr <= w_skid_instr;
               r_pc    <= w_skid_pc;
            end else if (r_req_vld) begin
               r_valid <= 1'b1;
               r_instr <= imem_rdata_i;
               r_pc    <= r_req_pc;
            end else begin
               r_valid <= 1'b0;
            end
         end
      end
   end

   assign instr_o = r_instr;
   assign pc_o    = r_pc;
   assign valid_o = r_valid;

endmodule
